deadline_multi: RTL and testbench

Multi-channel, parametrised instruction-deadline watchdog for the CPU's interrupt path. Each channel is armed by a start strobe and counts retired-instruction strobes. It raises a sticky timeout flag when its programmable threshold is reached and is cancelled by a stop (interrupt) strobe. Each channel runs in one-shot or periodic (auto-reload) mode. The block merges all pending flags into one prioritised interrupt request for the exception unit.

---
 rtl/deadline_pkg.sv | 16 +
 rtl/deadline_chan.sv | 84 ++++++++
 rtl/deadline_multi.sv | 61 ++++++
 tb/tb_deadline_multi.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/deadline_pkg.sv
// Shared types and constants for the instruction-deadline watchdog.
package deadline_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } chan_state_t;

    localparam logic ONE_SHOT = 1'b0;
    localparam logic PERIODIC = 1'b1;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_NUM_CH = 4;

endpackage

// File: rtl/deadline_chan.sv
// One deadline channel: instruction counter, run state, config and
// sticky timeout flag.
module deadline_chan
    import deadline_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int DEFAULT_THRESH = 63
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_count,
    input  logic             i_cfg_we,
    input  logic [CNT_W-1:0] i_cfg_thresh,
    input  logic             i_cfg_periodic,
    input  logic             i_ack,
    output logic             o_active,
    output logic             o_timeout
);

    chan_state_t      r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_thresh;
    logic             r_periodic;
    logic             r_timeout;

    logic [CNT_W-1:0] w_next;
    logic             w_inc;
    logic             w_hit;
    logic             w_cfg_ok;

    assign w_next = r_count + 1'b1;
    assign w_inc  = !i_stop && !i_start && (r_state == RUN) && i_count;
    // thresh==0 is a free-running counter; the wrap to 0 must not match
    assign w_hit  = w_inc && (r_thresh != '0) && (w_next == r_thresh);

    // a channel running now or entering RUN on this edge keeps its config
    assign w_cfg_ok = i_cfg_we && (r_state != RUN) &&
                      !(i_start && !i_stop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_thresh   <= CNT_W'(DEFAULT_THRESH);
            r_periodic <= ONE_SHOT;
            r_timeout  <= 1'b0;
        end else begin
            if (i_stop) begin
                r_state <= IDLE;
                r_count <= '0;
            end else if (i_start) begin
                r_state <= RUN;
                r_count <= '0;
            end else if (w_hit) begin
                if (r_periodic == PERIODIC) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_thresh;
                    r_state <= EXPIRED;
                end
            end else if (w_inc) begin
                r_count <= w_next;
            end

            if (i_stop)
                r_timeout <= 1'b0;
            else if (w_hit)
                r_timeout <= 1'b1;
            else if (i_ack)
                r_timeout <= 1'b0;

            if (w_cfg_ok) begin
                r_thresh   <= i_cfg_thresh;
                r_periodic <= i_cfg_periodic;
            end
        end
    end

    assign o_active  = (r_state == RUN);
    assign o_timeout = r_timeout;

endmodule

// File: rtl/deadline_multi.sv
// Multi-channel deadline watchdog: per-channel counters merged into one
// prioritised interrupt request.
module deadline_multi
    import deadline_pkg::*;
#(
    parameter int   NUM_CH         = DEF_NUM_CH,
    parameter int   CNT_W          = DEF_CNT_W,
    parameter int   DEFAULT_THRESH = 63,
    localparam int  CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              cpu_clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    input  logic              to_count,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              cfg_periodic,
    input  logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] timeout,
    output logic              irq,
    output logic [CH_W-1:0]   irq_ch
);

    logic [NUM_CH-1:0] w_cfg_we;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // out-of-range addresses match no channel
        assign w_cfg_we[i] = cfg_we && (int'(cfg_ch) == i);

        deadline_chan #(
            .CNT_W          (CNT_W),
            .DEFAULT_THRESH (DEFAULT_THRESH)
        ) u_ch (
            .i_clk          (cpu_clk),
            .i_rst_n        (rst_n),
            .i_start        (start[i]),
            .i_stop         (stop[i]),
            .i_count        (to_count),
            .i_cfg_we       (w_cfg_we[i]),
            .i_cfg_thresh   (cfg_thresh),
            .i_cfg_periodic (cfg_periodic),
            .i_ack          (ack[i]),
            .o_active       (active[i]),
            .o_timeout      (timeout[i])
        );
    end

    assign irq = |timeout;

    always_comb begin
        irq_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (timeout[i])
                irq_ch = CH_W'(i);
        end
    end

endmodule

// File: tb/tb_deadline_multi.sv
// Directed bench for deadline_multi with hand-computed expectations.
module tb_deadline_multi;

    logic       cpu_clk = 1'b0;
    logic       rst_n;
    logic [3:0] start;
    logic [3:0] stop;
    logic       to_count;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_thresh;
    logic       cfg_periodic;
    logic [3:0] ack;
    logic [3:0] active;
    logic [3:0] timeout;
    logic       irq;
    logic [1:0] irq_ch;

    int n_tot = 0;
    int n_bad = 0;

    always #5 cpu_clk = ~cpu_clk;

    deadline_multi dut (
        .cpu_clk      (cpu_clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .to_count     (to_count),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_thresh   (cfg_thresh),
        .cfg_periodic (cfg_periodic),
        .ack          (ack),
        .active       (active),
        .timeout      (timeout),
        .irq          (irq),
        .irq_ch       (irq_ch)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic counts(input int n);
        to_count = 1'b1;
        repeat (n) step();
        to_count = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [7:0] th,
                       input logic per);
        cfg_we       = 1'b1;
        cfg_ch       = ch;
        cfg_thresh   = th;
        cfg_periodic = per;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] m);
        start = m;
        step();
        start = '0;
    endtask

    task automatic pulse_ack(input logic [3:0] m);
        ack = m;
        step();
        ack = '0;
    endtask

    logic [3:0] exp_to;

    initial begin
        rst_n        = 1'b0;
        start        = '0;
        stop         = '0;
        to_count     = 1'b0;
        cfg_we       = 1'b0;
        cfg_ch       = '0;
        cfg_thresh   = '0;
        cfg_periodic = 1'b0;
        ack          = '0;

        // 1: reset and default threshold of 63
        repeat (3) step();
        chk("rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_active", 32'(active), 32'h0);
        chk("post_rst_irq", 32'({irq, irq_ch}), 32'h0);
        pulse_start(4'b0001);
        chk("t1_active", 32'(active), 32'h1);
        counts(62);
        chk("t1_before", 32'(timeout), 32'h0);
        counts(1);
        chk("t1_timeout", 32'(timeout), 32'h1);
        chk("t1_irq", 32'(irq), 32'h1);
        chk("t1_irq_ch", 32'(irq_ch), 32'h0);
        chk("t1_active_off", 32'(active), 32'h0);
        chk("t1_count", 32'(dut.g_ch[0].u_ch.r_count), 32'd63);
        pulse_ack(4'b0001);
        chk("t1_ack", 32'(timeout), 32'h0);

        // 2: periodic channel, ack between reloads
        cfg(2'd1, 8'd5, 1'b1);
        pulse_start(4'b0010);
        to_count = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            ack = (k == 7) ? 4'b0010 : 4'b0000;
            step();
            exp_to = ((k >= 5 && k <= 6) || k >= 10) ? 4'b0010 : 4'b0000;
            chk($sformatf("t2_to_k%0d", k), 32'(timeout), 32'(exp_to));
            chk($sformatf("t2_act_k%0d", k), 32'(active[1]), 32'h1);
        end
        to_count = 1'b0;
        ack      = '0;
        stop     = 4'b0010;
        step();
        stop = '0;
        chk("t2_stopped", 32'({active[1], timeout[1]}), 32'h0);

        // 3: stop beats start on the same edge
        pulse_start(4'b0100);
        counts(40);
        start = 4'b0100;
        stop  = 4'b0100;
        step();
        start = '0;
        stop  = '0;
        chk("t3_active", 32'(active[2]), 32'h0);
        chk("t3_count", 32'(dut.g_ch[2].u_ch.r_count), 32'h0);
        counts(100);
        chk("t3_timeout", 32'(timeout), 32'h0);
        chk("t3_irq", 32'(irq), 32'h0);

        // 4: set and ack colliding, set wins
        cfg(2'd0, 8'd3, 1'b0);
        pulse_start(4'b0001);
        counts(2);
        ack      = 4'b0001;
        to_count = 1'b1;
        step();
        ack      = '0;
        to_count = 1'b0;
        chk("t4_collide", 32'(timeout), 32'h1);
        pulse_ack(4'b0001);
        chk("t4_cleared", 32'(timeout), 32'h0);

        // 5: lowest-index priority
        cfg(2'd1, 8'd4, 1'b0);
        cfg(2'd3, 8'd4, 1'b0);
        pulse_start(4'b1010);
        counts(4);
        chk("t5_both", 32'(timeout), 32'hA);
        chk("t5_ch1", 32'(irq_ch), 32'd1);
        pulse_ack(4'b0010);
        chk("t5_ch3", 32'(irq_ch), 32'd3);
        chk("t5_irq_on", 32'(irq), 32'h1);
        pulse_ack(4'b1000);
        chk("t5_irq_off", 32'({irq, irq_ch}), 32'h0);

        // 6: config guard while running, then zero threshold wrap
        cfg(2'd0, 8'd63, 1'b0);
        start        = 4'b0001;
        cfg_we       = 1'b1;
        cfg_ch       = 2'd0;
        cfg_thresh   = 8'd2;
        cfg_periodic = 1'b0;
        step();
        start = '0;
        step();
        cfg_we = 1'b0;
        counts(62);
        chk("t6_guard_before", 32'(timeout), 32'h0);
        counts(1);
        chk("t6_guard_expire", 32'(timeout), 32'h1);
        cfg(2'd0, 8'd0, 1'b0);
        pulse_ack(4'b0001);
        pulse_start(4'b0001);
        counts(300);
        chk("t6_zero_to", 32'(timeout), 32'h0);
        chk("t6_zero_cnt", 32'(dut.g_ch[0].u_ch.r_count), 32'd44);
        chk("t6_zero_act", 32'(active[0]), 32'h1);

        // async reset mid-count clears without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_act", 32'(active), 32'h0);
        chk("rst_async_cnt", 32'(dut.g_ch[0].u_ch.r_count), 32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
